control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Hardwired Moore control sequencer that sits directly upstream of DataPath and drives every DataPath control input.
- It replaces the hand-sequenced T0..T7 stimulus currently used to exercise the datapath.
- Fetches, decodes IR[31:27] and steps each instruction through its micro-steps, then returns to fetch.
- Supports halt and an external stop request.

Parameters:
- OPW, 5, opcode field width (IR[31:27]) and width of the ALU opcode output.
- IRW, 32, instruction register width.

Ports:
- clock  in  1  system clock; all state changes on posedge.
- clear  in  1  synchronous, active-high reset.
- IR  in  32  current instruction register contents from DataPath.
- CON_out  in  1  branch condition flip-flop from DataPath.
- stop  in  1  level request to halt at the next fetch boundary.
- run  out  1  1 while sequencing; 0 in RESET_ST and HALTED.
- PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout  out  1 each  bus-drive selects.
- MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortin  out  1 each  register loads.
- IncPC, Read, Write, Gra, Grb, Grc  out  1 each  PC increment, memory strobes, register-field selects.
- opcode  out  5  ALU operation select.

Behaviour:
- State register: RESET_ST, T0..T7, HALTED.
- Outputs are purely combinational from (state, IR[31:27], CON_out). No output registers.
- Every output defaults to 0, including opcode = 5'b00000. Unlisted signals are 0 in each step.
- clear=1 at a posedge moves to RESET_ST from any state, mid-instruction included. All outputs are 0 and run=0 in that cycle.
- RESET_ST always advances to T0.
- Fetch (all instructions):
  - T0: PCout, MARin, IncPC, ZLowIn.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- Decode in T3 uses the IR value latched at the end of T2.
- ld: T3 Grb, BAout, Yin; T4 Cout, opcode=ADD, ZLowIn; T5 Zlowout, MARin; T6 Read, MDRin; T7 MDRout, Gra, Rin.
- ldi: T3 and T4 as ld; T5 Zlowout, Gra, Rin.
- st: T3 to T5 as ld; T6 Gra, Rout, MDRin (Read=0, so MDR loads from the bus); T7 Write.
- R-type ALU ops (add, sub, and, or, ror, rol, shr, shra, shl): T3 Grb, Rout, Yin; T4 Grc, Rout, opcode=IR[31:27], ZLowIn; T5 Zlowout, Gra, Rin.
- Immediate ops addi, andi, ori: T3 Grb, Rout, Yin; T4 Cout, opcode=ADD/AND/OR respectively, ZLowIn; T5 Zlowout, Gra, Rin.
- br: T3 Gra, Rout, CONin; T4 PCout, Yin; T5 Cout, opcode=ADD, ZLowIn; T6 Zlowout, with PCin = CON_out.
- jr: T3 Gra, Rout, PCin.
- in: T3 InPortout, Gra, Rin.
- out: T3 Gra, Rout, OutPortin.
- mfhi: T3 HIout, Gra, Rin.
- mflo: T3 LOout, Gra, Rin.
- nop, and any undefined opcode: T3 with all outputs 0.
- After an instruction's last step, next state is T0, or HALTED if stop=1 in that cycle.
- Instruction latency is 4 to 8 cycles: fetch (3) plus execute (1 to 5).
- halt: T3 outputs 0, then HALTED.
- HALTED holds with run=0 and all outputs 0 until clear.
- stop is sampled only in the last step of an instruction; an instruction in flight always completes.
- Memory is single-cycle. Read and Write are each asserted for exactly one cycle.

Decomposition:
- Shared package cpu_defs_pkg holds:
  - opcode constants: LD=00000, LDI=00001, ST=00010, ADD=00011, SUB=00100, AND=00101, OR=00110, ROR=00111, ROL=01000, SHR=01001, SHRA=01010, SHL=01011, ADDI=01100, ANDI=01101, ORI=01110, BR=10011, JR=10100, IN=10110, OUT=10111, MFHI=11000, MFLO=11001, NOP=11010, HALT=11011.
  - the state enumeration.
- Single module, no sub-modules. The next-state block and the output-decode block are separate always blocks.

Test Plan:
- clear=1 then 0, IR=0 -> RESET_ST with all outputs 0. T0 has PCout=MARin=IncPC=ZLowIn=1. T2 has MDRout=IRin=1.
- IR=0x00800075 (ld) -> T3..T7 as specified. opcode=00011 only in T4. Read=1 only in T1 and T6. Next fetch T0 at cycle 8.
- IR with opcode ST=00010 -> Write=1 only in T7. MDRin=1 with Read=0 in T6.
- IR opcode SUB=00100 -> opcode output 00100 in T4 only, Rin in T5, return to T0 after 6 cycles.
- IR opcode BR=10011 with CON_out=0, then a repeat with CON_out=1 -> PCin=0 in T6 on the first pass, PCin=1 in T6 on the second.
- IR opcode HALT=11011 -> HALTED, run=0. Separately: stop=1 raised during ld's T5 -> ld completes through T7, then HALTED. clear asserted in T4 of add -> RESET_ST next cycle with all outputs 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: instruction opcodes, control sequencer states and
// the per-opcode length of the execute phase.
package cpu_defs_pkg;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET_ST, T0, T1, T2, T3, T4, T5, T6, T7, HALTED
  } state_t;

  // Final micro-step of each instruction; single-step ops (and unknown ones) end in T3.
  function automatic state_t last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                             return T7;
      OP_BR:                                    return T6;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
      OP_ADDI, OP_ANDI, OP_ORI:                 return T5;
      default:                                  return T3;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the DataPath: fetch T0..T2, decode in
// T3, execute up to T7, with halt and a stop request sampled at instruction end.
module control_unit
  import cpu_defs_pkg::*;
#(
  parameter int OPW = 5,
  parameter int IRW = 32
) (
  input  logic           clock,
  input  logic           clear,
  input  logic [IRW-1:0] IR,
  input  logic           CON_out,
  input  logic           stop,
  output logic           run,
  output logic           PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
  output logic           InPortout, Cout, BAout, Rout,
  output logic           MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn,
  output logic           HIin, LOin, Rin, CONin, OutPortin,
  output logic           IncPC, Read, Write, Gra, Grb, Grc,
  output logic [OPW-1:0] opcode
);

  state_t         state_q, state_d;
  logic [OPW-1:0] op;
  logic           unused_ir;

  assign op        = IR[IRW-1 -: OPW];
  assign unused_ir = ^IR[IRW-OPW-1:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET_ST: state_d = T0;
      T0:       state_d = T1;
      T1:       state_d = T2;
      T2:       state_d = T3;
      HALTED:   state_d = HALTED;
      default: begin
        if (state_q == T3 && op == OP_HALT) begin
          state_d = HALTED;
        end else if (state_q == last_step(op)) begin
          state_d = stop ? HALTED : T0;
        end else begin
          case (state_q)
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = T7;
            default: state_d = T0;
          endcase
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    state_q <= clear ? RESET_ST : state_d;
  end

  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    run = 1'b0;
    PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; HIout = 1'b0;
    LOout = 1'b0; InPortout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0; Rin = 1'b0;
    CONin = 1'b0; OutPortin = 1'b0;
    IncPC = 1'b0; Read = 1'b0; Write = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    opcode = '0;

    run = (state_q != RESET_ST) && (state_q != HALTED);

    case (state_q)
      T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
      T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
          OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (op)
          OP_LD, OP_LDI, OP_ST: begin Cout = 1'b1; opcode = OP_ADD; ZLowIn = 1'b1; end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
          OP_SHL:  begin Grc = 1'b1; Rout = 1'b1; opcode = op; ZLowIn = 1'b1; end
          OP_ADDI: begin Cout = 1'b1; opcode = OP_ADD; ZLowIn = 1'b1; end
          OP_ANDI: begin Cout = 1'b1; opcode = OP_AND; ZLowIn = 1'b1; end
          OP_ORI:  begin Cout = 1'b1; opcode = OP_OR;  ZLowIn = 1'b1; end
          OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (op)
          OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
          OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
          OP_SHL, OP_ADDI, OP_ANDI, OP_ORI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_BR:   begin Cout = 1'b1; opcode = OP_ADD; ZLowIn = 1'b1; end
          default: ;
        endcase
      end
      T6: begin
        case (op)
          OP_LD:   begin Read = 1'b1; MDRin = 1'b1; end
          OP_ST:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          OP_BR:   begin Zlowout = 1'b1; PCin = CON_out; end
          default: ;
        endcase
      end
      T7: begin
        case (op)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboarded bench for control_unit: a driver queues the expected control
// word of every cycle from a micro-step table, a negedge monitor compares.
module tb_control_unit;

  logic        clock = 1'b0;
  logic        clear, CON_out, stop;
  logic [31:0] IR;
  logic        run;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout, Rout;
  logic        MARin, PCin, MDRin, IRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin, OutPortin;
  logic        IncPC, Read, Write, Gra, Grb, Grc;
  logic [4:0]  opcode;

  control_unit #(.OPW(5), .IRW(32)) dut (
    .clock(clock), .clear(clear), .IR(IR), .CON_out(CON_out), .stop(stop), .run(run),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn),
    .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .Rin(Rin), .CONin(CONin),
    .OutPortin(OutPortin), .IncPC(IncPC), .Read(Read), .Write(Write), .Gra(Gra),
    .Grb(Grb), .Grc(Grc), .opcode(opcode)
  );

  always #5 clock = ~clock;

  // Control word: one bit per control line above the 5-bit ALU opcode.
  typedef logic [33:0] ctl_t;
  typedef struct { ctl_t v; string tag; } exp_t;

  localparam ctl_t RUN  = 34'd1 << 5,  PCO  = 34'd1 << 6,  ZHO  = 34'd1 << 7,  ZLO  = 34'd1 << 8;
  localparam ctl_t MDRO = 34'd1 << 9,  HIO  = 34'd1 << 10, LOO  = 34'd1 << 11, INPO = 34'd1 << 12;
  localparam ctl_t CO   = 34'd1 << 13, BAO  = 34'd1 << 14, RO   = 34'd1 << 15, MARI = 34'd1 << 16;
  localparam ctl_t PCI  = 34'd1 << 17, MDRI = 34'd1 << 18, IRI  = 34'd1 << 19, YI   = 34'd1 << 20;
  localparam ctl_t ZLI  = 34'd1 << 21, ZHI  = 34'd1 << 22, HII  = 34'd1 << 23, LOI  = 34'd1 << 24;
  localparam ctl_t RI   = 34'd1 << 25, CONI = 34'd1 << 26, OUTI = 34'd1 << 27, INC  = 34'd1 << 28;
  localparam ctl_t RD   = 34'd1 << 29, WR   = 34'd1 << 30, GA   = 34'd1 << 31, GB   = 34'd1 << 32;
  localparam ctl_t GC   = 34'd1 << 33;

  localparam logic [4:0] C_LD = 5'd0, C_LDI = 5'd1, C_ST = 5'd2, C_ADD = 5'd3, C_SUB = 5'd4;
  localparam logic [4:0] C_AND = 5'd5, C_OR = 5'd6, C_SHL = 5'd11, C_ADDI = 5'd12;
  localparam logic [4:0] C_ANDI = 5'd13, C_ORI = 5'd14, C_BR = 5'd19, C_JR = 5'd20;
  localparam logic [4:0] C_IN = 5'd22, C_OUT = 5'd23, C_MFHI = 5'd24, C_MFLO = 5'd25;
  localparam logic [4:0] C_NOP = 5'd26, C_HALT = 5'd27;

  ctl_t obs;
  assign obs = {Grc, Grb, Gra, Write, Read, IncPC, OutPortin, CONin, Rin, LOin, HIin,
                ZHighIn, ZLowIn, Yin, IRin, MDRin, PCin, MARin, Rout, BAout, Cout,
                InPortout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout, run, opcode};

  exp_t exp_q[$];
  ctl_t plan[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input ctl_t got, input ctl_t want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic push(input ctl_t v, input string tag);
    exp_t e;
    e.v = v;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check(e.tag, obs, e.v);
    end
  end

  // Reference micro-program: the sequence of control words an instruction produces.
  task automatic build_plan(input logic [4:0] op, input logic con);
    ctl_t ex[$];
    ex = {};
    if (op inside {C_LD, C_LDI, C_ST})
      ex = {GB | BAO | YI, CO | ZLI | ctl_t'(C_ADD)};
    if (op == C_LD)  ex = {ex, ZLO | MARI, RD | MDRI, MDRO | GA | RI};
    if (op == C_LDI) ex = {ex, ZLO | GA | RI};
    if (op == C_ST)  ex = {ex, ZLO | MARI, GA | RO | MDRI, WR};
    if (op >= C_ADD && op <= C_SHL)
      ex = {GB | RO | YI, GC | RO | ZLI | ctl_t'(op), ZLO | GA | RI};
    if (op == C_ADDI) ex = {GB | RO | YI, CO | ZLI | ctl_t'(C_ADD), ZLO | GA | RI};
    if (op == C_ANDI) ex = {GB | RO | YI, CO | ZLI | ctl_t'(C_AND), ZLO | GA | RI};
    if (op == C_ORI)  ex = {GB | RO | YI, CO | ZLI | ctl_t'(C_OR),  ZLO | GA | RI};
    if (op == C_BR)
      ex = {GA | RO | CONI, PCO | YI, CO | ZLI | ctl_t'(C_ADD), ZLO | (con ? PCI : '0)};
    if (op == C_JR)   ex = {GA | RO | PCI};
    if (op == C_IN)   ex = {INPO | GA | RI};
    if (op == C_OUT)  ex = {GA | RO | OUTI};
    if (op == C_MFHI) ex = {HIO | GA | RI};
    if (op == C_MFLO) ex = {LOO | GA | RI};
    if (ex.size() == 0) ex = {ctl_t'(0)};
    plan = {PCO | MARI | INC | ZLI, ZLO | PCI | RD | MDRI, MDRO | IRI};
    foreach (ex[i]) plan.push_back(ex[i]);
    foreach (plan[i]) plan[i] = plan[i] | RUN;
  endtask

  // Drives one instruction; stop_mask[i] is the stop level during step Ti,
  // abort_at names a step in which clear is raised (out of range: none).
  task automatic run_instr(input logic [4:0] op, input logic con, input logic [7:0] stop_mask,
                           input int abort_at, input string name);
    int k;
    build_plan(op, con);
    k = plan.size();
    IR = {op, 27'($urandom)};
    CON_out = con;
    for (int i = 0; i < k; i++) begin
      stop = stop_mask[i];
      clear = (i == abort_at);
      push(plan[i], $sformatf("%s T%0d", name, i));
      @(posedge clock); #1;
      if (i == abort_at) begin
        push('0, $sformatf("%s reset after clear", name));
        clear = 1'b0;
        stop = 1'b0;
        @(posedge clock); #1;
        return;
      end
    end
    stop = 1'b0;
    if (op == C_HALT || stop_mask[k-1]) begin
      push('0, $sformatf("%s halted", name));
      @(posedge clock); #1;
      push('0, $sformatf("%s halted hold", name));
      clear = 1'b1;
      @(posedge clock); #1;
      push('0, $sformatf("%s reset from halt", name));
      clear = 1'b0;
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] rop;
    logic [7:0] mask;
    int         ab;
    clear = 1'b1; stop = 1'b0; CON_out = 1'b0; IR = 32'h0;
    @(posedge clock); #1;
    push('0, "reset state");
    clear = 1'b0;
    @(posedge clock); #1;

    IR = 32'h0080_0075;
    run_instr(C_LD, 1'b0, 8'h00, -1, "ld");
    run_instr(C_ST,   1'b0, 8'h00, -1, "st");
    run_instr(C_SUB,  1'b0, 8'h00, -1, "sub");
    run_instr(C_BR,   1'b0, 8'h00, -1, "br con0");
    run_instr(C_BR,   1'b1, 8'h00, -1, "br con1");
    run_instr(C_LDI,  1'b1, 8'h00, -1, "ldi");
    run_instr(C_ADDI, 1'b0, 8'h00, -1, "addi");
    run_instr(C_ANDI, 1'b0, 8'h00, -1, "andi");
    run_instr(C_ORI,  1'b0, 8'h00, -1, "ori");
    run_instr(C_JR,   1'b0, 8'h00, -1, "jr");
    run_instr(C_IN,   1'b0, 8'h00, -1, "in");
    run_instr(C_OUT,  1'b0, 8'h00, -1, "out");
    run_instr(C_MFHI, 1'b0, 8'h00, -1, "mfhi");
    run_instr(C_MFLO, 1'b0, 8'h00, -1, "mflo");
    run_instr(C_NOP,  1'b0, 8'h00, -1, "nop");
    run_instr(5'b11111, 1'b0, 8'h00, -1, "undef");
    run_instr(C_LD,   1'b0, 8'h10, -1, "ld stop pulse T4");
    run_instr(C_ADD,  1'b0, 8'h00, 4,  "add clear T4");
    run_instr(C_LD,   1'b0, 8'he0, -1, "ld stop from T5");
    run_instr(C_HALT, 1'b0, 8'h00, -1, "halt");

    for (int n = 0; n < 200; n++) begin
      rop  = 5'($urandom_range(0, 31));
      mask = 8'($urandom) & 8'($urandom) & 8'($urandom);
      ab   = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(rop, 1'($urandom_range(0, 1)), mask, ab, $sformatf("rand%0d op%b", n, rop));
    end

    repeat (3) @(posedge clock);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
